// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change dispenser: FSM states,
// denomination codes and their coin values.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DEN_50 = 2'd0,
    DEN_10 = 2'd1,
    DEN_5  = 2'd2,
    DEN_1  = 2'd3
  } denom_t;

  localparam logic [7:0] VALUE_50 = 8'd50;
  localparam logic [7:0] VALUE_10 = 8'd10;
  localparam logic [7:0] VALUE_5  = 8'd5;
  localparam logic [7:0] VALUE_1  = 8'd1;

  function automatic logic [7:0] denom_value(input logic [1:0] code);
    logic [7:0] v;
    case (denom_t'(code))
      DEN_50:  v = VALUE_50;
      DEN_10:  v = VALUE_10;
      DEN_5:   v = VALUE_5;
      default: v = VALUE_1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Payout request, hopper handshake, refill and status signals of the
// change dispenser, bundled with a driver-side and a dispenser-side view.
interface change_dispenser_if;
  logic       start;
  logic [7:0] change_amount;
  logic       coin_ack;
  logic       refill;
  logic [1:0] refill_sel;
  logic [7:0] refill_qty;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       busy;
  logic       done;
  logic [7:0] shortfall;
  logic       fault;

  modport master (
    output start, change_amount, coin_ack, refill, refill_sel, refill_qty,
    input  coin_req, coin_sel, busy, done, shortfall, fault
  );

  modport slave (
    input  start, change_amount, coin_ack, refill, refill_sel, refill_qty,
    output coin_req, coin_sel, busy, done, shortfall, fault
  );
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// Four saturating coin counters; refill and a one-coin decrement may hit the
// same counter in one cycle and are merged before saturation.
module coin_inventory
  import change_dispenser_pkg::*;
#(
  parameter logic [7:0] INIT_COUNT = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refill,
  input  logic [1:0] refill_sel,
  input  logic [7:0] refill_qty,
  input  logic       dec,
  input  logic [1:0] dec_sel,
  output logic [3:0] nonzero
);
  logic [7:0] count_r [4];
  logic [9:0] sum_s   [4];
  logic [7:0] next_s  [4];

  // Merge refill and decrement in 10 bits, then clamp to 255.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum_s[i] = {2'b00, count_r[i]}
               + (((refill == 1'b1) && (refill_sel == 2'(i))) ? {2'b00, refill_qty} : 10'd0)
               - (((dec == 1'b1) && (dec_sel == 2'(i))) ? 10'd1 : 10'd0);
      next_s[i]  = (sum_s[i] > 10'd255) ? 8'd255 : sum_s[i][7:0];
      nonzero[i] = (count_r[i] != 8'd0);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) count_r[i] <= INIT_COUNT;
    end else begin
      for (int i = 0; i < 4; i++) count_r[i] <= next_s[i];
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: picks the largest affordable stocked coin, issues
// it to the hopper, and waits for the acknowledge with a fault timeout.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter logic [7:0] INIT_COUNT  = 8'd20,
  parameter int         ACK_TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t          state_r,     state_s;
  logic [7:0]      remaining_r, remaining_s;
  logic [TW-1:0]   timeout_r,   timeout_s;
  logic [1:0]      coin_sel_r,  coin_sel_s;
  logic [7:0]      shortfall_r, shortfall_s;
  logic            coin_req_r, busy_r, done_r, fault_r;
  logic            dec_s;
  logic [3:0]      nonzero_s;
  logic [3:0]      elig_s;
  logic [1:0]      pick_sel_s;
  logic            pick_found_s;

  coin_inventory #(.INIT_COUNT(INIT_COUNT)) u_inv (
    .clk        (clk),
    .reset      (reset),
    .refill     (bus.refill),
    .refill_sel (bus.refill_sel),
    .refill_qty (bus.refill_qty),
    .dec        (dec_s),
    .dec_sel    (coin_sel_r),
    .nonzero    (nonzero_s)
  );

  // Greedy choice: code 0 is the largest coin, so lowest eligible code wins.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig_s[i] = nonzero_s[i] && (denom_value(2'(i)) <= remaining_r);
    end
    pick_found_s = |elig_s;
    if (elig_s[0])      pick_sel_s = DEN_50;
    else if (elig_s[1]) pick_sel_s = DEN_10;
    else if (elig_s[2]) pick_sel_s = DEN_5;
    else                pick_sel_s = DEN_1;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    timeout_s   = timeout_r;
    coin_sel_s  = coin_sel_r;
    shortfall_s = shortfall_r;
    dec_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          remaining_s = bus.change_amount;
          shortfall_s = 8'd0;
          state_s     = ST_SELECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (remaining_r == 8'd0) begin
          shortfall_s = 8'd0;
          state_s     = ST_DONE;
        end else if (pick_found_s) begin
          coin_sel_s = pick_sel_s;
          timeout_s  = {TW{1'b0}};
          state_s    = ST_ISSUE;
        end else begin
          shortfall_s = remaining_r;
          state_s     = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (bus.coin_ack) begin
          remaining_s = remaining_r - denom_value(coin_sel_r);
          dec_s       = 1'b1;
          state_s     = ST_SELECT;
        end else begin
          timeout_s = timeout_r + {{(TW-1){1'b0}}, 1'b1};
          if (timeout_s == TW'(ACK_TIMEOUT)) state_s = ST_FAULT;
          else                               state_s = ST_ISSUE;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      ST_FAULT: state_s = ST_FAULT;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      remaining_r <= 8'd0;
      timeout_r   <= {TW{1'b0}};
      coin_sel_r  <= 2'd0;
      shortfall_r <= 8'd0;
      coin_req_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      timeout_r   <= timeout_s;
      coin_sel_r  <= coin_sel_s;
      shortfall_r <= shortfall_s;
      coin_req_r  <= (state_s == ST_ISSUE);
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_DONE);
      fault_r     <= (state_s == ST_FAULT);
    end
  end

  assign bus.coin_req  = coin_req_r;
  assign bus.coin_sel  = coin_sel_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.shortfall = shortfall_r;
  assign bus.fault     = fault_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: directed scenarios plus random payouts compared with a
// greedy reference model of coin counts, coin order, shortfall and latency.
module tb_change_dispenser;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cnt_m [4];
  int   val_m [4] = '{50, 10, 5, 1};

  change_dispenser_if bus ();

  change_dispenser #(.INIT_COUNT(8'd20), .ACK_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check_counts(input string tag);
    for (int d = 0; d < 4; d++) check_value({tag, "_cnt"}, dut.u_inv.count_r[d], cnt_m[d]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_value("rst_req",   bus.coin_req,  0);
    check_value("rst_sel",   bus.coin_sel,  0);
    check_value("rst_busy",  bus.busy,      0);
    check_value("rst_done",  bus.done,      0);
    check_value("rst_short", bus.shortfall, 0);
    check_value("rst_fault", bus.fault,     0);
    for (int d = 0; d < 4; d++) cnt_m[d] = 20;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_refill(input int sel, input int qty);
    @(negedge clk);
    bus.refill = 1'b1; bus.refill_sel = 2'(sel); bus.refill_qty = 8'(qty);
    @(negedge clk);
    bus.refill = 1'b0;
    cnt_m[sel] = sat255(cnt_m[sel] + qty);
  endtask

  // One payout; the hopper acks dly cycles after seeing coin_req. A refill
  // on the first ack cycle is only used with single-coin amounts.
  task automatic payout(input string tag, input int amt, input int dly, input bit poke,
                        input bit ra_en, input int ra_sel, input int ra_qty);
    int exp_q[$];
    int rem, n, cyc, want, cur;
    bit first;
    rem = amt;
    for (int d = 0; d < 4; d++) begin
      while (cnt_m[d] > 0 && rem >= val_m[d]) begin
        exp_q.push_back(d); rem -= val_m[d]; cnt_m[d]--;
      end
    end
    n = exp_q.size();
    if (ra_en) cnt_m[ra_sel] = sat255(cnt_m[ra_sel] + ra_qty);
    first = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.change_amount = 8'(amt);
    @(negedge clk);
    bus.start = 1'b0; bus.change_amount = 8'($urandom_range(0, 255));
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4000) begin
      if (bus.coin_req === 1'b1) begin
        if (exp_q.size() > 0) want = exp_q.pop_front(); else want = -1;
        cur = int'(bus.coin_sel);
        check_value({tag, "_sel"}, bus.coin_sel, want);
        for (int k = 0; k < dly; k++) begin
          if (poke && k == 0) begin bus.start = 1'b1; bus.change_amount = 8'd5; end
          @(negedge clk); cyc++;
          bus.start = 1'b0;
          check_value({tag, "_hold_req"}, bus.coin_req, 1);
          check_value({tag, "_hold_sel"}, bus.coin_sel, cur);
        end
        bus.coin_ack = 1'b1;
        if (ra_en && first) begin
          bus.refill = 1'b1; bus.refill_sel = 2'(ra_sel); bus.refill_qty = 8'(ra_qty);
        end
        @(negedge clk); cyc++;
        bus.coin_ack = 1'b0; bus.refill = 1'b0; first = 1'b0;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check_value({tag, "_done"},    bus.done, 1);
    check_value({tag, "_latency"}, cyc, n * (dly + 2) + 1);
    check_value({tag, "_short"},   bus.shortfall, rem);
    check_value({tag, "_left"},    exp_q.size(), 0);
    check_value({tag, "_busy_d"},  bus.busy, 1);
    @(negedge clk);
    check_value({tag, "_pulse"},   bus.done, 0);
    check_value({tag, "_idle"},    bus.busy, 0);
    check_value({tag, "_short_h"}, bus.shortfall, rem);
    check_counts(tag);
  endtask

  initial begin
    int t, w, sum;
    bit seen;
    total = 0; bad = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.change_amount = 8'd0; bus.coin_ack = 1'b0;
    bus.refill = 1'b0; bus.refill_sel = 2'd0; bus.refill_qty = 8'd0;
    for (int d = 0; d < 4; d++) cnt_m[d] = 20;
    repeat (3) @(negedge clk);
    check_value("por_busy", bus.busy, 0);
    check_counts("por");
    reset = 1'b1;

    payout("zero", 0, 0, 1'b0, 1'b0, 0, 0);
    payout("r67", 67, 2, 1'b1, 1'b0, 0, 0);
    check_value("r67_c3", dut.u_inv.count_r[3], 18);

    // Empty the 5s, refill them with nothing, then 15 must use 10+1s.
    apply_reset();
    for (int i = 0; i < 20; i++) payout("drain5", 5, 0, 1'b0, 1'b0, 0, 0);
    do_refill(2, 0);
    payout("r15", 15, 1, 1'b0, 1'b0, 0, 0);

    apply_reset();
    sum = 80;
    while (sum > 0) begin
      payout("drain", 255, 0, 1'b0, 1'b0, 0, 0);
      sum = cnt_m[0] + cnt_m[1] + cnt_m[2] + cnt_m[3];
    end
    payout("empty30", 30, 0, 1'b0, 1'b0, 0, 0);
    check_value("empty30_sf", bus.shortfall, 30);

    apply_reset();
    do_refill(3, 250);
    check_value("sat255", dut.u_inv.count_r[3], 255);
    payout("ackref", 10, 1, 1'b1, 1'b1, 1, 5);
    check_value("ackref_c1", dut.u_inv.count_r[1], 24);
    payout("ackref_sat", 1, 0, 1'b0, 1'b1, 3, 10);

    // Reset while a coin is outstanding: payout is dropped, no done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.change_amount = 8'd67;
    @(negedge clk);
    bus.start = 1'b0;
    w = 0;
    while (bus.coin_req !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check_value("abandon_req", bus.coin_req, 1);
    apply_reset();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (bus.done === 1'b1) seen = 1'b1; end
    check_value("abandon_done", seen, 0);
    check_counts("abandon");

    // Hopper never acks: fault after 16 ISSUE cycles, then sticky.
    @(negedge clk);
    bus.start = 1'b1; bus.change_amount = 8'd50;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0; w = 0;
    while (bus.fault !== 1'b1 && w < 100) begin
      if (bus.coin_req === 1'b1) t++;
      @(negedge clk); w++;
    end
    check_value("flt_set",   bus.fault, 1);
    check_value("flt_cycles", t, 16);
    check_value("flt_req",   bus.coin_req, 0);
    check_value("flt_busy",  bus.busy, 1);
    bus.start = 1'b1; bus.change_amount = 8'd0; bus.coin_ack = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.coin_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.coin_req === 1'b1) seen = 1'b1;
    end
    check_value("flt_ignore", seen, 0);
    check_value("flt_sticky", bus.fault, 1);
    do_refill(0, 7);
    check_counts("flt_refill");
    apply_reset();
    check_value("flt_clear", bus.fault, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) do_refill(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      payout("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
